// File: rtl/c64_bus_arbiter.sv
// Three-requester arbiter for a single C64 bus cycle port.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module c64_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_20,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [47:0] req_addr,
    input  logic [2:0]  req_rw,
    input  logic [23:0] req_wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        bus_start,
    output logic [15:0] bus_addr,
    output logic        bus_rw,
    output logic [7:0]  bus_wdata,
    input  logic        bus_done,
    input  logic [7:0]  bus_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [2:0]  gnt_n, done_n;
    logic        err_n, start_n, rw_n;
    logic [7:0]  rdata_n, wdata_n;
    logic [15:0] addr_n;
    logic [1:0]  win;
    logic [15:0] sel_addr;
    logic        sel_rw;
    logic [7:0]  sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr, ptr_n;

    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Search order starts at the requester after the last winner.
    always_comb begin
        logic [1:0] c0, c1, c2;
        c0 = ptr;
        c1 = nxt(c0);
        c2 = nxt(c1);
        if (req[c0])      win = c0;
        else if (req[c1]) win = c1;
        else              win = c2;
    end

    always_ff @(posedge clk_20) begin
        if (rst) ptr <= 2'd0;
        else     ptr <= ptr_n;
    end
`else
    always_comb begin
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
    end
`endif

    always_comb begin
        unique case (win)
            2'd0: begin
                sel_addr  = req_addr[15:0];
                sel_rw    = req_rw[0];
                sel_wdata = req_wdata[7:0];
            end
            2'd1: begin
                sel_addr  = req_addr[31:16];
                sel_rw    = req_rw[1];
                sel_wdata = req_wdata[15:8];
            end
            default: begin
                sel_addr  = req_addr[47:32];
                sel_rw    = req_rw[2];
                sel_wdata = req_wdata[23:16];
            end
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt_n   = gnt;
        done_n  = 3'b000;
        err_n   = 1'b0;
        start_n = 1'b0;
        rdata_n = rdata;
        addr_n  = bus_addr;
        rw_n    = bus_rw;
        wdata_n = bus_wdata;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_n   = ptr;
`endif
        unique case (state)
            IDLE: begin
                gnt_n = 3'b000;
                if (req != 3'b000) begin
                    gnt_n   = 3'b001 << win;
                    addr_n  = sel_addr;
                    rw_n    = sel_rw;
                    wdata_n = sel_wdata;
                    state_n = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_n   = nxt(win);
`endif
                end
            end
            ISSUE: begin
                start_n = 1'b1;
                cnt_n   = 8'd0;
                state_n = WAIT;
            end
            WAIT: begin
                // A bus_done in the timeout cycle still returns real data.
                if (bus_done) begin
                    done_n  = gnt;
                    if (bus_rw) rdata_n = bus_rdata;
                    state_n = DONE;
                end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                    done_n  = gnt;
                    err_n   = 1'b1;
                    rdata_n = 8'hFF;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DONE: begin
                gnt_n   = 3'b000;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_20) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            gnt       <= 3'b000;
            done      <= 3'b000;
            err       <= 1'b0;
            bus_start <= 1'b0;
            rdata     <= 8'd0;
            bus_addr  <= 16'd0;
            bus_rw    <= 1'b1;
            bus_wdata <= 8'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            done      <= done_n;
            err       <= err_n;
            bus_start <= start_n;
            rdata     <= rdata_n;
            bus_addr  <= addr_n;
            bus_rw    <= rw_n;
            bus_wdata <= wdata_n;
        end
    end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Bench for c64_bus_arbiter: transaction-timeline model plus directed cases.
// Builds with or without ARB_ROUND_ROBIN_EN.
module tb_c64_bus_arbiter;

    localparam int TMO = 8;

    logic        clk_20 = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [47:0] req_addr = 48'd0;
    logic [2:0]  req_rw = 3'b111;
    logic [23:0] req_wdata = 24'd0;
    logic        bus_done = 1'b0;
    logic [7:0]  bus_rdata = 8'd0;
    logic [2:0]  gnt, done;
    logic        err, bus_start, bus_rw;
    logic [7:0]  rdata, bus_wdata;
    logic [15:0] bus_addr;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #25 clk_20 = ~clk_20;

    c64_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_20(clk_20), .rst(rst), .req(req),
        .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .bus_start(bus_start),
        .bus_addr(bus_addr), .bus_rw(bus_rw),
        .bus_wdata(bus_wdata), .bus_done(bus_done),
        .bus_rdata(bus_rdata)
    );

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: each transaction is a timeline relative to its acceptance edge.
    logic [2:0]  m_gnt, m_done;
    logic        m_err, m_start, m_rw;
    logic [7:0]  m_rdata, m_wdata;
    logic [15:0] m_addr;
    int cyc = 0, t0 = 0, tc = 0, ptr = 0;
    bit busy = 0, fin = 0;

    function automatic int pick(input logic [2:0] r, input int p);
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 3; i++)
            if (r[(p + i) % 3]) return (p + i) % 3;
`else
        for (int i = 0; i < 3; i++)
            if (r[i]) return i + 0 * p;
`endif
        return 0;
    endfunction

    always @(posedge clk_20) begin
        int w, rel;
        cyc++;
        if (rst) begin
            busy = 0; fin = 0; ptr = 0;
            m_gnt = 0; m_done = 0; m_err = 0; m_start = 0;
            m_addr = 0; m_rw = 1; m_wdata = 0; m_rdata = 0;
        end else begin
            m_done = 0; m_err = 0; m_start = 0;
            if (!busy) begin
                if (req != 0) begin
                    w = pick(req, ptr);
                    ptr = (w + 1) % 3;
                    busy = 1; fin = 0; t0 = cyc;
                    m_gnt = 3'b001 << w;
                    m_addr = req_addr[16*w +: 16];
                    m_rw = req_rw[w];
                    m_wdata = req_wdata[8*w +: 8];
                end
            end else begin
                rel = cyc - t0;
                if (rel == 1) begin
                    m_start = 1;
                end else if (!fin) begin
                    if (bus_done || rel - 1 == TMO) begin
                        fin = 1; tc = cyc; m_done = m_gnt;
                        if (bus_done) begin
                            if (m_rw) m_rdata = bus_rdata;
                        end else begin
                            m_err = 1; m_rdata = 8'hFF;
                        end
                    end
                end else if (cyc == tc + 1) begin
                    busy = 0; m_gnt = 0;
                end
            end
        end
    end

    always @(negedge clk_20) begin
        if (chk_en) begin
            chk("gnt", gnt, m_gnt);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("rdata", rdata, m_rdata);
            chk("bus_start", bus_start, m_start);
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_rw", bus_rw, m_rw);
            chk("bus_wdata", bus_wdata, m_wdata);
        end
    end

    task automatic serve(output logic [2:0] g);
        int k;
        k = 0;
        while (gnt == 0 && k < 20) begin @(negedge clk_20); k++; end
        g = gnt;
        while (!bus_start && k < 40) begin @(negedge clk_20); k++; end
        bus_done = 1; bus_rdata = 8'($urandom);
        @(negedge clk_20);
        bus_done = 0;
        while (gnt != 0 && k < 60) begin @(negedge clk_20); k++; end
        chk("serve_bound", (k >= 60) ? 16'd1 : 16'd0, 16'd0);
    endtask

    logic [2:0] exp_order [4];

    initial begin
        logic [2:0] g;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_order = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        repeat (2) @(negedge clk_20);
        rst = 0; chk_en = 1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_rw", bus_rw, 1);
        chk("rst_rdata", rdata, 0);

        req_addr[15:0] = 16'hD020; req = 3'b001;
        @(negedge clk_20);
        chk("r032_gnt", gnt, 3'b001);
        chk("r032_start_early", bus_start, 0);
        @(negedge clk_20);
        chk("r032_start", bus_start, 1);
        chk("r032_addr", bus_addr, 16'hD020);
        chk("r032_rw", bus_rw, 1);
        repeat (5) @(negedge clk_20);
        bus_done = 1; bus_rdata = 8'h0E;
        @(negedge clk_20);
        bus_done = 0; req = 0;
        chk("r032_done", done, 3'b001);
        chk("r032_rdata", rdata, 8'h0E);
        chk("r032_err", err, 0);
        @(negedge clk_20);
        chk("r032_done_off", done, 0);
        chk("r032_gnt_off", gnt, 0);

        rst = 1; @(negedge clk_20); rst = 0;
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            serve(g);
            chk($sformatf("r033_gnt%0d", i), g, exp_order[i]);
        end
        req = 0; @(negedge clk_20);

        req = 3'b100;
        repeat (9) @(negedge clk_20);
        chk("r034_pre", done, 0);
        @(negedge clk_20);
        chk("r034_done", done, 3'b100);
        chk("r034_err", err, 1);
        chk("r034_rdata", rdata, 8'hFF);
        req = 0;
        @(negedge clk_20);
        chk("r034_idle", gnt, 0);
        chk("r034_err_off", err, 0);

        req_addr[31:16] = 16'h1234; req_rw[1] = 0;
        req_wdata[15:8] = 8'hA5; req = 3'b010;
        @(negedge clk_20);
        req_wdata[15:8] = 8'h3C; req_addr[31:16] = 16'hFFFF;
        @(negedge clk_20);
        chk("r035_start", bus_start, 1);
        chk("r035_wdata", bus_wdata, 8'hA5);
        chk("r035_rw", bus_rw, 0);
        chk("r035_addr", bus_addr, 16'h1234);
        bus_done = 1; bus_rdata = 8'h77;
        @(negedge clk_20);
        bus_done = 0; req = 0;
        chk("r035_done", done, 3'b010);
        chk("r035_err", err, 0);
        chk("r035_rdata", rdata, 8'hFF);
        req_rw[1] = 1;
        @(negedge clk_20);

        req = 3'b001;
        repeat (9) @(negedge clk_20);
        chk("r037_pre", done, 0);
        bus_done = 1; bus_rdata = 8'h5A;
        @(negedge clk_20);
        bus_done = 0; req = 0;
        chk("r037_done", done, 3'b001);
        chk("r037_err", err, 0);
        chk("r037_rdata", rdata, 8'h5A);
        @(negedge clk_20);

        req = 3'b001;
        repeat (3) @(negedge clk_20);
        rst = 1;
        @(negedge clk_20);
        rst = 0; req = 0; bus_done = 1;
        chk("r036_gnt", gnt, 0);
        chk("r036_addr", bus_addr, 0);
        chk("r036_rw", bus_rw, 1);
        chk("r036_wdata", bus_wdata, 0);
        chk("r036_rdata", rdata, 0);
        @(negedge clk_20);
        bus_done = 0;
        chk("r036_done", done, 0);
        chk("r036_err", err, 0);
        chk("r036_start", bus_start, 0);
        req = 3'b010;
        serve(g);
        chk("r036_next", g, 3'b010);
        req = 0;
        @(negedge clk_20);

        for (int c = 0; c < 4000; c++) begin
            for (int n = 0; n < 3; n++) begin
                if (req[n]) begin
                    if (done[n] ? ($urandom_range(1) == 1)
                                : ($urandom_range(31) == 0))
                        req[n] = 0;
                end else if ($urandom_range(3) == 0) begin
                    req[n] = 1;
                end
                if ($urandom_range(3) == 0)
                    req_addr[16*n +: 16] = 16'($urandom);
                if ($urandom_range(3) == 0)
                    req_rw[n] = 1'($urandom);
                if ($urandom_range(3) == 0)
                    req_wdata[8*n +: 8] = 8'($urandom);
            end
            bus_done = ($urandom_range(5) == 0);
            bus_rdata = 8'($urandom);
            rst = ($urandom_range(299) == 0);
            @(negedge clk_20);
        end
        rst = 0; req = 0; bus_done = 0;
        repeat (4) @(negedge clk_20);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
